// File: rtl/clock_12h_ctrl_pkg.sv
// clock_12h_ctrl_pkg
// Shared types and constants for the 12-hour clock run/set controller.
//   - state_t      : controller FSM state encoding (driven out on `mode`)
//   - BCD limits   : hour/minute ranges and reset values
//   - bcd_in_range : legality check applied to counter values captured on set entry
// Optional feature macro: CLOCK_12H_CTRL_ALARM_EN adds the alarm-setting states.
package clock_12h_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        SET_HH    = 3'd1,
        SET_MM    = 3'd2
`ifdef CLOCK_12H_CTRL_ALARM_EN
        ,
        SET_AL_HH = 3'd3,
        SET_AL_MM = 3'd4
`endif
    } state_t;

    localparam logic [7:0] HH_MIN     = 8'h01;
    localparam logic [7:0] HH_MAX     = 8'h12;
    localparam logic [7:0] MM_MIN     = 8'h00;
    localparam logic [7:0] MM_MAX     = 8'h59;
    localparam logic [7:0] HH_RST     = 8'h12;
    localparam logic [7:0] MM_RST     = 8'h00;
    // Stepping away from 11 lands on 12, which is where AM/PM flips.
    localparam logic [7:0] HH_PM_FLIP = 8'h11;

    // True when v is a well-formed BCD byte inside [lo, hi]. For legal BCD the
    // binary ordering matches the decimal ordering, so plain compares suffice.
    function automatic logic bcd_in_range(input logic [7:0] v,
                                          input logic [7:0] lo,
                                          input logic [7:0] hi);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/clock_12h_ctrl_bcd_step.sv
// bcd_step
// Combinational 8-bit BCD increment with wrap from MAX back to MIN.
//   val  in  8  current BCD value (assumed legal and within MIN..MAX)
//   nxt  out 8  val + 1 in BCD, or MIN when val is at MAX
//   wrap out 1  high when this step wraps MAX -> MIN
module bcd_step
    import clock_12h_ctrl_pkg::*;
#(
    parameter logic [7:0] MIN = MM_MIN,
    parameter logic [7:0] MAX = MM_MAX
) (
    input  logic [7:0] val,
    output logic [7:0] nxt,
    output logic       wrap
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
        nxt  = val;
        wrap = 1'b0;
        if (val >= MAX) begin
            nxt  = MIN;
            wrap = 1'b1;
        end else if (val[3:0] >= 4'd9) begin
            nxt = {val[7:4] + 4'd1, 4'd0};
        end else begin
            nxt = {val[7:4], val[3:0] + 4'd1};
        end
    end

endmodule

// File: rtl/clock_12h_ctrl.sv
// clock_12h_ctrl
// Run/set controller for the 12-hour BCD time counter: seconds prescaler,
// two-button set FSM on shadow registers, and a one-cycle commit strobe.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   btn_mode, btn_inc       debounced button levels (rising edge acts)
//   hh_cur, mm_cur, pm_cur  live counter time (BCD)
//   ena                     one-cycle seconds-advance pulse
//   load                    one-cycle commit strobe for hh_load/mm_load/pm_load
//   hh_load, mm_load, pm_load  shadow time being edited / committed
//   mode                    current FSM state encoding
//   alarm_hit               one-cycle alarm pulse (0 unless alarm option built)
// Optional feature macro: CLOCK_12H_CTRL_ALARM_EN (alarm set states + alarm_hit).
module clock_12h_ctrl
    import clock_12h_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [7:0] hh_cur,
    input  logic [7:0] mm_cur,
    input  logic       pm_cur,
    output logic       ena,
    output logic       load,
    output logic [7:0] hh_load,
    output logic [7:0] mm_load,
    output logic       pm_load,
    output logic [2:0] mode,
    output logic       alarm_hit
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             btn_mode_q, btn_inc_q;
    logic             mode_edge, inc_edge;

    logic [7:0] hh_sel, mm_sel, hh_nxt, mm_nxt;
    logic       hh_wrap, mm_wrap;
    logic       unused_wrap;

`ifdef CLOCK_12H_CTRL_ALARM_EN
    logic [7:0] al_hh, al_mm;
    logic       al_pm;
    logic       al_match, al_match_q;

    // The alarm fields share the shadow incrementers.
    assign hh_sel = (state == SET_AL_HH) ? al_hh : hh_load;
    assign mm_sel = (state == SET_AL_MM) ? al_mm : mm_load;
`else
    assign hh_sel = hh_load;
    assign mm_sel = mm_load;
`endif

    bcd_step #(.MIN(HH_MIN), .MAX(HH_MAX)) u_hh_step (
        .val  (hh_sel),
        .nxt  (hh_nxt),
        .wrap (hh_wrap)
    );

    bcd_step #(.MIN(MM_MIN), .MAX(MM_MAX)) u_mm_step (
        .val  (mm_sel),
        .nxt  (mm_nxt),
        .wrap (mm_wrap)
    );

    // Minutes never carry into hours and 12->01 does not flip AM/PM, so the wrap flags go unused here.
    assign unused_wrap = hh_wrap | mm_wrap;

    assign mode = state;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state      <= RUN;
            cnt        <= '0;
            btn_mode_q <= 1'b0;
            btn_inc_q  <= 1'b0;
            mode_edge  <= 1'b0;
            inc_edge   <= 1'b0;
            ena        <= 1'b0;
            load       <= 1'b0;
            hh_load    <= HH_RST;
            mm_load    <= MM_RST;
            pm_load    <= 1'b0;
`ifdef CLOCK_12H_CTRL_ALARM_EN
            al_hh      <= HH_RST;
            al_mm      <= MM_RST;
            al_pm      <= 1'b0;
`endif
        end else begin
            // Edges are registered so a press acts two edges after the level rises.
            btn_mode_q <= btn_mode;
            btn_inc_q  <= btn_inc;
            mode_edge  <= btn_mode & ~btn_mode_q;
            inc_edge   <= btn_inc & ~btn_inc_q;
            ena        <= 1'b0;
            load       <= 1'b0;

            case (state)
                RUN: begin
                    if (mode_edge) begin
                        // Prescaler holds while setting; illegal live values fall back to 12:00.
                        state   <= SET_HH;
                        hh_load <= bcd_in_range(hh_cur, HH_MIN, HH_MAX) ? hh_cur : HH_RST;
                        mm_load <= bcd_in_range(mm_cur, MM_MIN, MM_MAX) ? mm_cur : MM_RST;
                        pm_load <= pm_cur;
                    end else if (cnt == CNT_MAX) begin
                        cnt <= '0;
                        ena <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                SET_HH: begin
                    if (mode_edge) begin
                        state <= SET_MM;
                    end else if (inc_edge) begin
                        hh_load <= hh_nxt;
                        if (hh_load == HH_PM_FLIP) pm_load <= ~pm_load;
                    end
                end

                SET_MM: begin
                    if (mode_edge) begin
                        // Commit: the counter restarts its second, so the prescaler does too.
                        load <= 1'b1;
                        cnt  <= '0;
`ifdef CLOCK_12H_CTRL_ALARM_EN
                        state <= SET_AL_HH;
`else
                        state <= RUN;
`endif
                    end else if (inc_edge) begin
                        mm_load <= mm_nxt;
                    end
                end

`ifdef CLOCK_12H_CTRL_ALARM_EN
                // Time keeps running while the alarm is edited.
                SET_AL_HH, SET_AL_MM: begin
                    if (cnt == CNT_MAX) begin
                        cnt <= '0;
                        ena <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    if (mode_edge) begin
                        state <= (state == SET_AL_HH) ? SET_AL_MM : RUN;
                    end else if (inc_edge) begin
                        if (state == SET_AL_HH) begin
                            al_hh <= hh_nxt;
                            if (al_hh == HH_PM_FLIP) al_pm <= ~al_pm;
                        end else begin
                            al_mm <= mm_nxt;
                        end
                    end
                end
`endif

                default: state <= RUN;
            endcase
        end
    end

`ifdef CLOCK_12H_CTRL_ALARM_EN
    assign al_match = (state == RUN) && (hh_cur == al_hh) && (mm_cur == al_mm) && (pm_cur == al_pm);

    // Pulse only on the rising edge of the match so a held time fires once.
    always_ff @(posedge clk) begin
        if (reset) begin
            al_match_q <= 1'b0;
            alarm_hit  <= 1'b0;
        end else begin
            al_match_q <= al_match;
            alarm_hit  <= al_match & ~al_match_q;
        end
    end
`else
    assign alarm_hit = 1'b0;
`endif

endmodule

// File: tb/tb_clock_12h_ctrl.sv
// tb_clock_12h_ctrl
// Directed self-checking bench for clock_12h_ctrl with TICK_DIV=4.
// The alarm scenario is compiled only when CLOCK_12H_CTRL_ALARM_EN is defined.
module tb_clock_12h_ctrl;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset, btn_mode, btn_inc;
    logic [7:0] hh_cur, mm_cur;
    logic       pm_cur;
    logic       ena, load, pm_load, alarm_hit;
    logic [7:0] hh_load, mm_load;
    logic [2:0] mode;

    int checks = 0;
    int failures = 0;

    // Event bookkeeping updated on every sampled cycle.
    int   cyc = 0;
    int   load_cnt = 0;
    int   load_cyc = -1;
    int   last_ena_cyc = -1;
    int   ena_viol = 0;
    int   hit_cnt = 0;
    logic [7:0] ld_hh, ld_mm;
    logic       ld_pm;

    always #5 clk = ~clk;

    clock_12h_ctrl #(.TICK_DIV(TICK_DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .hh_cur    (hh_cur),
        .mm_cur    (mm_cur),
        .pm_cur    (pm_cur),
        .ena       (ena),
        .load      (load),
        .hh_load   (hh_load),
        .mm_load   (mm_load),
        .pm_load   (pm_load),
        .mode      (mode),
        .alarm_hit (alarm_hit)
    );

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (load) begin
            load_cnt++;
            load_cyc = cyc;
            ld_hh = hh_load;
            ld_mm = mm_load;
            ld_pm = pm_load;
        end
        if (ena) last_ena_cyc = cyc;
        if (ena && (mode == 3'd1 || mode == 3'd2 || load)) ena_viol++;
        if (alarm_hit) hit_cnt++;
    endtask

    // Raise the requested buttons, let the action land, then release.
    task automatic press(input logic m, input logic i);
        btn_mode = m;
        btn_inc  = i;
        tick();
        tick();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
        hh_cur = 8'h12; mm_cur = 8'h00; pm_cur = 1'b0;
        repeat (3) tick();
        checks++; if (mode !== 3'd0) begin failures++; $display("FAIL reset_mode got=%0d exp=0", mode); end
        checks++; if (ena !== 1'b0) begin failures++; $display("FAIL reset_ena got=%b exp=0", ena); end
        checks++; if (load !== 1'b0) begin failures++; $display("FAIL reset_load got=%b exp=0", load); end
        checks++; if (hh_load !== 8'h12) begin failures++; $display("FAIL reset_hh got=%h exp=12", hh_load); end
        checks++; if (mm_load !== 8'h00) begin failures++; $display("FAIL reset_mm got=%h exp=00", mm_load); end
        checks++; if (pm_load !== 1'b0) begin failures++; $display("FAIL reset_pm got=%b exp=0", pm_load); end
        checks++; if (alarm_hit !== 1'b0) begin failures++; $display("FAIL reset_alarm got=%b exp=0", alarm_hit); end
    endtask

    // ena expected in cycles 4, 8, 12 after reset release and never elsewhere.
    task automatic test_tick_rate();
        logic exp_ena;
        reset = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            tick();
            exp_ena = ((k % TICK_DIV) == 0);
            checks++;
            if (ena !== exp_ena) begin
                failures++;
                $display("FAIL tick_rate cycle=%0d got=%b exp=%b", k, ena, exp_ena);
            end
        end
    endtask

    task automatic test_set_commit();
        int lc0;
        lc0 = load_cnt;
        ena_viol = 0;
        hh_cur = 8'h11; mm_cur = 8'h58; pm_cur = 1'b0;
        press(1'b1, 1'b0);
        checks++; if (mode !== 3'd1) begin failures++; $display("FAIL set_enter_mode got=%0d exp=1", mode); end
        checks++; if (hh_load !== 8'h11 || mm_load !== 8'h58) begin failures++; $display("FAIL set_capture got=%h:%h exp=11:58", hh_load, mm_load); end
        press(1'b0, 1'b1);
        checks++; if (hh_load !== 8'h12 || pm_load !== 1'b1) begin failures++; $display("FAIL set_hh_11_to_12 got=%h pm=%b exp=12 pm=1", hh_load, pm_load); end
        press(1'b1, 1'b0);
        checks++; if (mode !== 3'd2) begin failures++; $display("FAIL set_mm_mode got=%0d exp=2", mode); end
        press(1'b0, 1'b1);
        checks++; if (mm_load !== 8'h59) begin failures++; $display("FAIL set_mm_58_59 got=%h exp=59", mm_load); end
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        checks++; if (mm_load !== 8'h01 || hh_load !== 8'h12) begin failures++; $display("FAIL set_mm_wrap got=%h:%h exp=12:01", hh_load, mm_load); end
        press(1'b1, 1'b0);
        checks++; if (mode !== 3'd0) begin failures++; $display("FAIL commit_mode got=%0d exp=0", mode); end
        checks++; if (load_cnt - lc0 !== 1) begin failures++; $display("FAIL commit_load_count got=%0d exp=1", load_cnt - lc0); end
        checks++; if (ld_hh !== 8'h12 || ld_mm !== 8'h01 || ld_pm !== 1'b1) begin failures++; $display("FAIL commit_values got=%h:%h pm=%b exp=12:01 pm=1", ld_hh, ld_mm, ld_pm); end
        for (int i = 0; i < 20; i++) begin
            if (last_ena_cyc > load_cyc) break;
            tick();
        end
        checks++; if (last_ena_cyc - load_cyc !== TICK_DIV) begin failures++; $display("FAIL commit_ena_delay got=%0d exp=%0d", last_ena_cyc - load_cyc, TICK_DIV); end
        checks++; if (ena_viol !== 0) begin failures++; $display("FAIL ena_while_setting got=%0d exp=0", ena_viol); end
        checks++; if (hh_load !== 8'h12 || mm_load !== 8'h01) begin failures++; $display("FAIL shadow_stable got=%h:%h exp=12:01", hh_load, mm_load); end
    endtask

    task automatic test_hour_wrap();
        hh_cur = 8'h12; mm_cur = 8'h30; pm_cur = 1'b0;
        press(1'b1, 1'b0);
        checks++; if (hh_load !== 8'h12 || pm_load !== 1'b0) begin failures++; $display("FAIL wrap_entry got=%h pm=%b exp=12 pm=0", hh_load, pm_load); end
        press(1'b0, 1'b1);
        checks++; if (hh_load !== 8'h01 || pm_load !== 1'b0) begin failures++; $display("FAIL hour_wrap got=%h pm=%b exp=01 pm=0", hh_load, pm_load); end
    endtask

    task automatic test_simultaneous();
        press(1'b1, 1'b1);
        checks++; if (mode !== 3'd2) begin failures++; $display("FAIL simul_mode got=%0d exp=2", mode); end
        checks++; if (hh_load !== 8'h01 || mm_load !== 8'h30) begin failures++; $display("FAIL simul_values got=%h:%h exp=01:30", hh_load, mm_load); end
    endtask

    task automatic test_reset_mid();
        int lc0;
        lc0 = load_cnt;
        reset = 1'b1;
        tick();
        checks++; if (mode !== 3'd0) begin failures++; $display("FAIL midreset_mode got=%0d exp=0", mode); end
        checks++; if (load !== 1'b0) begin failures++; $display("FAIL midreset_load got=%b exp=0", load); end
        checks++; if (hh_load !== 8'h12) begin failures++; $display("FAIL midreset_hh got=%h exp=12", hh_load); end
        reset = 1'b0;
        repeat (6) tick();
        checks++; if (load_cnt !== lc0) begin failures++; $display("FAIL midreset_no_load got=%0d exp=%0d", load_cnt, lc0); end
    endtask

    task automatic test_illegal_capture();
        hh_cur = 8'h1A; mm_cur = 8'h7B; pm_cur = 1'b1;
        press(1'b1, 1'b0);
        checks++; if (hh_load !== 8'h12 || mm_load !== 8'h00 || pm_load !== 1'b1) begin failures++; $display("FAIL illegal_capture got=%h:%h pm=%b exp=12:00 pm=1", hh_load, mm_load, pm_load); end
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        hh_cur = 8'h09; mm_cur = 8'h00; pm_cur = 1'b0;
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        checks++; if (hh_load !== 8'h10) begin failures++; $display("FAIL bcd_09_10 got=%h exp=10", hh_load); end
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        checks++; if (hh_load !== 8'h12 || pm_load !== 1'b1) begin failures++; $display("FAIL pm_flip got=%h pm=%b exp=12 pm=1", hh_load, pm_load); end
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
`ifndef CLOCK_12H_CTRL_ALARM_EN
        checks++; if (mode !== 3'd0) begin failures++; $display("FAIL return_run got=%0d exp=0", mode); end
`else
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        checks++; if (mode !== 3'd0) begin failures++; $display("FAIL return_run got=%0d exp=0", mode); end
`endif
    endtask

`ifdef CLOCK_12H_CTRL_ALARM_EN
    task automatic test_alarm();
        hh_cur = 8'h01; mm_cur = 8'h00; pm_cur = 1'b0;
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        checks++; if (mode !== 3'd3) begin failures++; $display("FAIL alarm_hh_mode got=%0d exp=3", mode); end
        // 12 AM -> 12 PM takes 12 steps, then 7 more reach 07 PM.
        repeat (19) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        checks++; if (mode !== 3'd4) begin failures++; $display("FAIL alarm_mm_mode got=%0d exp=4", mode); end
        repeat (30) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        checks++; if (mode !== 3'd0) begin failures++; $display("FAIL alarm_exit_mode got=%0d exp=0", mode); end
        hit_cnt = 0;
        hh_cur = 8'h07; mm_cur = 8'h30; pm_cur = 1'b0;
        repeat (5) tick();
        checks++; if (hit_cnt !== 0) begin failures++; $display("FAIL alarm_am_no_hit got=%0d exp=0", hit_cnt); end
        pm_cur = 1'b1;
        repeat (10) tick();
        checks++; if (hit_cnt !== 1) begin failures++; $display("FAIL alarm_hit_count got=%0d exp=1", hit_cnt); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_tick_rate();
        test_set_commit();
        test_hour_wrap();
        test_simultaneous();
        test_reset_mid();
        test_illegal_capture();
`ifdef CLOCK_12H_CTRL_ALARM_EN
        test_alarm();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
